// File: rtl/wb_dma_ng_pkg.sv
// Shared definitions for the next-generation DMA channel register file:
// register offsets, CSR bit positions and interrupt-source indices.
package wb_dma_ng_pkg;

  // Register offsets within a channel slot (wb_rf_adr[2:0])
  localparam logic [2:0] REG_CSR  = 3'd0;
  localparam logic [2:0] REG_TXSZ = 3'd1;
  localparam logic [2:0] REG_ADR0 = 3'd2;
  localparam logic [2:0] REG_AM0  = 3'd3;
  localparam logic [2:0] REG_ADR1 = 3'd4;
  localparam logic [2:0] REG_AM1  = 3'd5;
  localparam logic [2:0] REG_PTR  = 3'd6;
  localparam logic [2:0] REG_RSVD = 3'd7;

  // CSR bit positions
  localparam int CSR_EN      = 0;
  localparam int CSR_INC_SRC = 1;
  localparam int CSR_INC_DST = 2;
  localparam int CSR_MODE    = 3;
  localparam int CSR_ARS     = 4;
  localparam int CSR_USE_ED  = 5;
  localparam int CSR_STOP    = 6;
  localparam int CSR_BUSY    = 12;
  localparam int CSR_DONE    = 13;
  localparam int CSR_ERR     = 14;
  localparam int CSR_MSK_LO  = 15;
  localparam int CSR_SRC_LO  = 18;

  // TXSZ chunk field position
  localparam int TXSZ_CHK_LO = 16;
  localparam int TXSZ_CHK_W  = 9;

  // Interrupt source indices inside INT_MSK / INT_SRC
  localparam int NUM_INT = 3;
  typedef enum logic [1:0] {
    INT_ERR   = 2'd0,
    INT_DONE  = 2'd1,
    INT_CHUNK = 2'd2
  } int_idx_e;

  typedef logic [NUM_INT-1:0] int_vec_t;

  // Software read/write control bits, CSR[5:0] (en is the LSB)
  typedef struct packed {
    logic use_ed;
    logic ars;
    logic mode;
    logic inc_dst;
    logic inc_src;
    logic en;
  } csr_ctl_t;

  // Assemble the architectural CSR view; STOP and unused bits read 0
  function automatic logic [31:0] csr_pack(input csr_ctl_t ctl, input logic busy,
                                           input logic done, input logic err,
                                           input int_vec_t msk, input int_vec_t src);
    logic [31:0] v;
    v = '0;
    v[CSR_USE_ED:CSR_EN]          = ctl;
    v[CSR_BUSY]                   = busy;
    v[CSR_DONE]                   = done;
    v[CSR_ERR]                    = err;
    v[CSR_MSK_LO +: NUM_INT]      = msk;
    v[CSR_SRC_LO +: NUM_INT]      = src;
    return v;
  endfunction

endpackage

// File: rtl/wb_dma_ch_rf_ng_irq.sv
// Interrupt source latch with clear-on-read and registered interrupt output.
import wb_dma_ng_pkg::*;

module wb_dma_ch_rf_ng_irq (
  input  logic     clk,
  input  logic     rst,
  input  int_vec_t evt,
  input  int_vec_t msk,
  input  logic     rd_clr,
  output int_vec_t int_src,
  output logic     intt
);

  // Masked events set their source bit; a CSR read clears, but a same-cycle event wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      int_src <= '0;
      intt    <= 1'b0;
    end else begin
      int_src <= (rd_clr ? int_vec_t'('0) : int_src) | (evt & msk);
      intt    <= |(int_src & msk);
    end
  end

endmodule

// File: rtl/wb_dma_ch_rf_ng.sv
// One DMA channel register slot: CSR, transfer size, addresses/masks,
// descriptor pointer, auto-restart shadows and interrupt generation.
// Address and mask registers hold the low ADR_W bits of the write data and
// read back zero-extended. CH_EN=0 disables all decode so every register
// stays at its reset value of zero.
import wb_dma_ng_pkg::*;

module wb_dma_ch_rf_ng #(
  parameter int CH_ADR   = 0,
  parameter int CH_EN    = 1,
  parameter int TXSZ_W   = 12,
  parameter int ADR_W    = 30,
  parameter int HAVE_ARS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        wb_rf_adr,
  input  logic [31:0]       wb_rf_din,
  input  logic              wb_rf_we,
  input  logic              wb_rf_re,
  output logic [31:0]       rf_dout,
  input  logic [4:0]        ch_sel,
  input  logic              dma_busy,
  input  logic              dma_done,
  input  logic              dma_err,
  input  logic              dma_chunk,
  input  logic              de_csr_we,
  input  logic              de_txsz_we,
  input  logic              de_adr0_we,
  input  logic              de_adr1_we,
  input  logic [TXSZ_W-1:0] de_txsz,
  input  logic [ADR_W-1:0]  de_adr0,
  input  logic [ADR_W-1:0]  de_adr1,
  output logic [31:0]       ch_csr,
  output logic [31:0]       ch_txsz,
  output logic [ADR_W-1:0]  ch_adr0,
  output logic [ADR_W-1:0]  ch_adr1,
  output logic [ADR_W-1:0]  ch_am0,
  output logic [ADR_W-1:0]  ch_am1,
  output logic [31:0]       pointer,
  output logic              ch_enable,
  output logic              ch_stop,
  output logic              intt
);

  localparam bit SLOT_ON = (CH_EN != 0);
  localparam bit ARS_ON  = (HAVE_ARS != 0);

  // Decode
  logic [2:0] off;
  logic       hit, sel, sw_we, sw_re;
  logic       sw_csr, sw_txsz, sw_adr0, sw_am0, sw_adr1, sw_am1, sw_ptr;
  logic       done_e, err_e, chunk_e, de_csr_e, ars_reload;

  assign off     = wb_rf_adr[2:0];
  assign hit     = SLOT_ON && (wb_rf_adr[7:3] == 5'(CH_ADR));
  assign sel     = SLOT_ON && (ch_sel == 5'(CH_ADR));
  assign sw_we   = wb_rf_we & hit;
  assign sw_re   = wb_rf_re & hit;
  assign sw_csr  = sw_we & (off == REG_CSR);
  assign sw_txsz = sw_we & (off == REG_TXSZ);
  assign sw_adr0 = sw_we & (off == REG_ADR0);
  assign sw_am0  = sw_we & (off == REG_AM0);
  assign sw_adr1 = sw_we & (off == REG_ADR1);
  assign sw_am1  = sw_we & (off == REG_AM1);
  assign sw_ptr  = sw_we & (off == REG_PTR);

  assign done_e   = dma_done & sel;
  assign err_e    = dma_err & sel;
  assign chunk_e  = dma_chunk & sel;
  // The engine's CSR write-back carries no data: it hands the channel back (EN=0)
  assign de_csr_e = de_csr_we & sel;

  // State
  csr_ctl_t           ctl_q, ctl_wr;
  logic               done_q, err_q, busy_q, stop_q;
  int_vec_t           msk_q, int_src, evt;
  logic [TXSZ_CHK_W-1:0] chunk_q;
  logic [TXSZ_W-1:0]  total_q, total_sh;
  logic [ADR_W-1:0]   adr0_q, adr0_sh, adr1_q, adr1_sh, am0_q, am1_q;
  logic [31:0]        ptr_q;
  logic [31:0]        csr_view, rd_mux;
  logic [15:0]        total_ext;

  // Auto-restart only on a clean done; an error alongside done stops the channel
  assign ars_reload = ARS_ON & ctl_q.ars & done_e & ~err_e;

  // Control bits as written by software; STOP overrides EN, ARS absent when not built
  always_comb begin
    ctl_wr     = csr_ctl_t'(wb_rf_din[CSR_USE_ED:CSR_EN]);
    ctl_wr.en  = wb_rf_din[CSR_EN] & ~wb_rf_din[CSR_STOP];
    ctl_wr.ars = wb_rf_din[CSR_ARS] & ARS_ON;
  end

  // CSR control, sticky status, busy mirror and stop pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctl_q  <= '0;
      msk_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
      stop_q <= 1'b0;
    end else begin
      busy_q <= dma_busy & sel;
      stop_q <= sw_csr & wb_rf_din[CSR_STOP];
      if (sw_csr) begin
        ctl_q <= ctl_wr;
        msk_q <= wb_rf_din[CSR_MSK_LO +: NUM_INT];
      end else if ((done_e & ~ars_reload) | err_e | de_csr_e) begin
        ctl_q.en <= 1'b0;
      end
      if (done_e & ~ars_reload)         done_q <= 1'b1;
      else if (sw_csr & wb_rf_din[CSR_EN]) done_q <= 1'b0;
      if (err_e)                         err_q <= 1'b1;
      else if (sw_csr & wb_rf_din[CSR_EN]) err_q <= 1'b0;
    end
  end

  // Size and address fields: software beats ARS reload beats engine write-back
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chunk_q  <= '0;
      total_q  <= '0;
      total_sh <= '0;
      adr0_q   <= '0;
      adr0_sh  <= '0;
      adr1_q   <= '0;
      adr1_sh  <= '0;
      am0_q    <= '0;
      am1_q    <= '0;
      ptr_q    <= '0;
    end else begin
      if (sw_txsz) begin
        chunk_q  <= wb_rf_din[TXSZ_CHK_LO +: TXSZ_CHK_W];
        total_q  <= wb_rf_din[TXSZ_W-1:0];
        total_sh <= wb_rf_din[TXSZ_W-1:0];
      end else if (ars_reload) begin
        total_q <= total_sh;
      end else if (de_txsz_we & sel) begin
        total_q <= de_txsz;
      end

      if (sw_adr0) begin
        adr0_q  <= wb_rf_din[ADR_W-1:0];
        adr0_sh <= wb_rf_din[ADR_W-1:0];
      end else if (ars_reload) begin
        adr0_q <= adr0_sh;
      end else if (de_adr0_we & sel) begin
        adr0_q <= de_adr0;
      end

      if (sw_adr1) begin
        adr1_q  <= wb_rf_din[ADR_W-1:0];
        adr1_sh <= wb_rf_din[ADR_W-1:0];
      end else if (ars_reload) begin
        adr1_q <= adr1_sh;
      end else if (de_adr1_we & sel) begin
        adr1_q <= de_adr1;
      end

      if (sw_am0) am0_q <= wb_rf_din[ADR_W-1:0];
      if (sw_am1) am1_q <= wb_rf_din[ADR_W-1:0];
      if (sw_ptr) ptr_q <= wb_rf_din;
    end
  end

  // Interrupt events in INT index order
  always_comb begin
    evt            = '0;
    evt[INT_ERR]   = err_e;
    evt[INT_DONE]  = done_e;
    evt[INT_CHUNK] = chunk_e;
  end

  wb_dma_ch_rf_ng_irq u_irq (
    .clk     (clk),
    .rst     (rst),
    .evt     (evt),
    .msk     (msk_q),
    .rd_clr  (sw_re & (off == REG_CSR)),
    .int_src (int_src),
    .intt    (intt)
  );

  // Output views
  always_comb begin
    total_ext             = '0;
    total_ext[TXSZ_W-1:0] = total_q;
  end

  assign csr_view  = csr_pack(ctl_q, busy_q, done_q, err_q, msk_q, int_src);
  assign ch_csr    = csr_view;
  assign ch_txsz   = {7'd0, chunk_q, total_ext};
  assign ch_adr0   = adr0_q;
  assign ch_adr1   = adr1_q;
  assign ch_am0    = am0_q;
  assign ch_am1    = am1_q;
  assign pointer   = ptr_q;
  assign ch_enable = ctl_q.en & ~stop_q;
  assign ch_stop   = stop_q;

  // Read-data mux; reserved offset reads 0
  always_comb begin
    rd_mux = '0;
    case (off)
      REG_CSR:  rd_mux = csr_view;
      REG_TXSZ: rd_mux = ch_txsz;
      REG_ADR0: rd_mux[ADR_W-1:0] = adr0_q;
      REG_AM0:  rd_mux[ADR_W-1:0] = am0_q;
      REG_ADR1: rd_mux[ADR_W-1:0] = adr1_q;
      REG_AM1:  rd_mux[ADR_W-1:0] = am1_q;
      REG_PTR:  rd_mux = ptr_q;
      default:  rd_mux = '0;
    endcase
  end

  // Registered read data, held until the next read of this slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       rf_dout <= '0;
    else if (sw_re) rf_dout <= rd_mux;
  end

endmodule

// File: tb/tb_wb_dma_ch_rf_ng.sv
// Bench for wb_dma_ch_rf_ng: register table sweep, interrupt, auto-restart,
// collision, stop and reset sequences, plus a CH_EN=0 slot on the same bus.
module tb_wb_dma_ch_rf_ng;
  localparam int SLOT   = 5;
  localparam int TXSZ_W = 12;
  localparam int ADR_W  = 30;
  localparam logic [2:0] O_CSR = 3'd0, O_TXSZ = 3'd1, O_ADR0 = 3'd2, O_AM0 = 3'd3,
                         O_ADR1 = 3'd4, O_AM1 = 3'd5, O_PTR = 3'd6, O_RSVD = 3'd7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]        wb_rf_adr = '0;
  logic [31:0]       wb_rf_din = '0;
  logic              wb_rf_we = 1'b0, wb_rf_re = 1'b0;
  logic [4:0]        ch_sel = '0;
  logic              dma_busy = 1'b0, dma_done = 1'b0, dma_err = 1'b0, dma_chunk = 1'b0;
  logic              de_csr_we = 1'b0, de_txsz_we = 1'b0, de_adr0_we = 1'b0, de_adr1_we = 1'b0;
  logic [TXSZ_W-1:0] de_txsz = '0;
  logic [ADR_W-1:0]  de_adr0 = '0, de_adr1 = '0;

  logic [31:0]      rf_dout, ch_csr, ch_txsz, pointer;
  logic [ADR_W-1:0] ch_adr0, ch_adr1, ch_am0, ch_am1;
  logic             ch_enable, ch_stop, intt;

  logic [31:0]      d_rf_dout, d_csr, d_txsz, d_pointer;
  logic [ADR_W-1:0] d_adr0, d_adr1, d_am0, d_am1;
  logic             d_enable, d_stop, d_intt;

  wb_dma_ch_rf_ng #(.CH_ADR(SLOT), .CH_EN(1), .TXSZ_W(TXSZ_W), .ADR_W(ADR_W), .HAVE_ARS(1)) dut (
    .clk(clk), .rst(rst), .wb_rf_adr(wb_rf_adr), .wb_rf_din(wb_rf_din), .wb_rf_we(wb_rf_we),
    .wb_rf_re(wb_rf_re), .rf_dout(rf_dout), .ch_sel(ch_sel), .dma_busy(dma_busy),
    .dma_done(dma_done), .dma_err(dma_err), .dma_chunk(dma_chunk), .de_csr_we(de_csr_we),
    .de_txsz_we(de_txsz_we), .de_adr0_we(de_adr0_we), .de_adr1_we(de_adr1_we),
    .de_txsz(de_txsz), .de_adr0(de_adr0), .de_adr1(de_adr1), .ch_csr(ch_csr),
    .ch_txsz(ch_txsz), .ch_adr0(ch_adr0), .ch_adr1(ch_adr1), .ch_am0(ch_am0),
    .ch_am1(ch_am1), .pointer(pointer), .ch_enable(ch_enable), .ch_stop(ch_stop), .intt(intt));

  wb_dma_ch_rf_ng #(.CH_ADR(SLOT), .CH_EN(0), .TXSZ_W(TXSZ_W), .ADR_W(ADR_W), .HAVE_ARS(1)) dis (
    .clk(clk), .rst(rst), .wb_rf_adr(wb_rf_adr), .wb_rf_din(wb_rf_din), .wb_rf_we(wb_rf_we),
    .wb_rf_re(wb_rf_re), .rf_dout(d_rf_dout), .ch_sel(ch_sel), .dma_busy(dma_busy),
    .dma_done(dma_done), .dma_err(dma_err), .dma_chunk(dma_chunk), .de_csr_we(de_csr_we),
    .de_txsz_we(de_txsz_we), .de_adr0_we(de_adr0_we), .de_adr1_we(de_adr1_we),
    .de_txsz(de_txsz), .de_adr0(de_adr0), .de_adr1(de_adr1), .ch_csr(d_csr),
    .ch_txsz(d_txsz), .ch_adr0(d_adr0), .ch_adr1(d_adr1), .ch_am0(d_am0),
    .ch_am1(d_am1), .pointer(d_pointer), .ch_enable(d_enable), .ch_stop(d_stop), .intt(d_intt));

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  logic re_seen = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] out_of(input logic [2:0] off);
    case (off)
      O_CSR:   return ch_csr;
      O_TXSZ:  return ch_txsz;
      O_ADR0:  return {2'b0, ch_adr0};
      O_AM0:   return {2'b0, ch_am0};
      O_ADR1:  return {2'b0, ch_adr1};
      O_AM1:   return {2'b0, ch_am1};
      O_PTR:   return pointer;
      default: return 32'h0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] slot, input logic [2:0] off, input logic [31:0] d);
    wb_rf_adr = {slot, off};
    wb_rf_din = d;
    wb_rf_we  = 1'b1;
    tick();
    wb_rf_we  = 1'b0;
  endtask

  task automatic rd(input logic [2:0] off, input logic [31:0] e);
    wb_rf_adr = {5'(SLOT), off};
    wb_rf_re  = 1'b1;
    exp_q.push_back(e);
    tick();
    wb_rf_re  = 1'b0;
  endtask

  // Scoreboard side: a read of our slot produces rf_dout after the edge
  always @(posedge clk) re_seen <= wb_rf_re && (wb_rf_adr[7:3] == 5'(SLOT)) && rst;

  always @(negedge clk) begin
    if (re_seen) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rd_data: got 0x%08h with no expected value queued", rf_dout);
      end else begin
        check("rd_data", rf_dout, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  off;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;
  localparam int NV = 10;
  vec_t vecs[NV];

  initial begin
    vecs[0] = '{O_TXSZ, 32'hFFFF_FFFF, 32'h01FF_0FFF};
    vecs[1] = '{O_ADR0, 32'hFFFF_FFFF, 32'h3FFF_FFFF};
    vecs[2] = '{O_AM0,  32'h1234_5678, 32'h1234_5678};
    vecs[3] = '{O_ADR1, 32'hC000_0004, 32'h0000_0004};
    vecs[4] = '{O_AM1,  32'h0ABC_DEF0, 32'h0ABC_DEF0};
    vecs[5] = '{O_PTR,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[6] = '{O_RSVD, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[7] = '{O_CSR,  32'hFFFF_FFFE, 32'h0003_803E};
    vecs[8] = '{O_CSR,  32'h0000_0000, 32'h0000_0000};
    vecs[9] = '{O_TXSZ, 32'h0010_0040, 32'h0010_0040};

    // Power-on reset
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("rst_csr", ch_csr, 32'h0);
    check("rst_txsz", ch_txsz, 32'h0);
    check("rst_adr0", {2'b0, ch_adr0}, 32'h0);
    check("rst_ptr", pointer, 32'h0);
    check("rst_dout", rf_dout, 32'h0);
    check("rst_flags", {29'b0, intt, ch_enable, ch_stop}, 32'h0);

    // Register sweep: write, check output view, read back through scoreboard
    for (int i = 0; i < NV; i++) begin
      wr(5'(SLOT), vecs[i].off, vecs[i].wd);
      if (vecs[i].off != O_RSVD) check($sformatf("out_%0d", i), out_of(vecs[i].off), vecs[i].exp);
      rd(vecs[i].off, vecs[i].exp);
    end
    wr(5'(SLOT + 1), O_ADR0, 32'h0000_0055);
    check("other_slot", {2'b0, ch_adr0}, 32'h3FFF_FFFF);

    // Done with only ERR unmasked: no interrupt, chunk ignored
    ch_sel = 5'(SLOT);
    wr(5'(SLOT), O_CSR, 32'h0000_8001);
    check("en_on", {31'b0, ch_enable}, 32'h1);
    dma_done = 1'b1; dma_chunk = 1'b1;
    tick();
    dma_done = 1'b0; dma_chunk = 1'b0;
    check("done_csr", ch_csr, 32'h0000_A000);
    check("done_en", {31'b0, ch_enable}, 32'h0);
    tick();
    check("done_intt_masked", {31'b0, intt}, 32'h0);

    // Done with DONE unmasked: interrupt, clear-on-read
    wr(5'(SLOT), O_CSR, 32'h0001_0001);
    check("en_clears_done", ch_csr, 32'h0001_0001);
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    check("int_src_set", ch_csr, 32'h0009_2000);
    tick();
    check("intt_set", {31'b0, intt}, 32'h1);
    rd(O_CSR, 32'h0009_2000);
    check("intt_hold", {31'b0, intt}, 32'h1);
    check("int_src_clr", ch_csr, 32'h0001_2000);
    tick();
    check("intt_clr", {31'b0, intt}, 32'h0);

    // Clear-on-read racing a new done event: event wins
    wr(5'(SLOT), O_CSR, 32'h0001_0001);
    wb_rf_adr = {5'(SLOT), O_CSR};
    wb_rf_re = 1'b1; dma_done = 1'b1;
    exp_q.push_back(32'h0001_0001);
    tick();
    wb_rf_re = 1'b0; dma_done = 1'b0;
    check("evt_wins", ch_csr, 32'h0009_2000);
    rd(O_CSR, 32'h0009_2000);
    repeat (2) tick();

    // Auto-restart reload
    wr(5'(SLOT), O_ADR0, 32'h0000_0100);
    wr(5'(SLOT), O_ADR1, 32'h0000_0080);
    wr(5'(SLOT), O_CSR, 32'h0001_0011);
    de_txsz = '0; de_adr0 = 30'h140; de_adr1 = 30'h1C0;
    de_txsz_we = 1'b1; de_adr0_we = 1'b1; de_adr1_we = 1'b1;
    tick();
    de_txsz_we = 1'b0; de_adr0_we = 1'b0; de_adr1_we = 1'b0;
    check("de_txsz", ch_txsz, 32'h0010_0000);
    check("de_adr0", {2'b0, ch_adr0}, 32'h140);
    check("de_adr1", {2'b0, ch_adr1}, 32'h1C0);
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    check("ars_txsz", ch_txsz, 32'h0010_0040);
    check("ars_adr0", {2'b0, ch_adr0}, 32'h100);
    check("ars_adr1", {2'b0, ch_adr1}, 32'h080);
    check("ars_csr", ch_csr, 32'h0009_0011);
    check("ars_en", {31'b0, ch_enable}, 32'h1);
    tick();
    check("ars_intt", {31'b0, intt}, 32'h1);

    // Asynchronous reset mid-transfer
    #2 rst = 1'b0;
    #1;
    check("mrst_csr", ch_csr, 32'h0);
    check("mrst_txsz", ch_txsz, 32'h0);
    check("mrst_adr", {2'b0, ch_adr0 | ch_adr1 | ch_am0 | ch_am1}, 32'h0);
    check("mrst_ptr", pointer, 32'h0);
    check("mrst_dout", rf_dout, 32'h0);
    check("mrst_flags", {29'b0, intt, ch_enable, ch_stop}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // Software and engine writing ADR0 together; engine ADR1 alongside
    de_adr0 = 30'h300; de_adr1 = 30'h3C0;
    de_adr0_we = 1'b1; de_adr1_we = 1'b1;
    wr(5'(SLOT), O_ADR0, 32'h0000_0200);
    de_adr0_we = 1'b0; de_adr1_we = 1'b0;
    check("coll_adr0", {2'b0, ch_adr0}, 32'h200);
    check("coll_adr1", {2'b0, ch_adr1}, 32'h3C0);

    // STOP pulse beats EN
    wr(5'(SLOT), O_CSR, 32'h0000_0001);
    check("stop_pre_en", {31'b0, ch_enable}, 32'h1);
    wr(5'(SLOT), O_CSR, 32'h0000_0041);
    check("stop_pulse", {31'b0, ch_stop}, 32'h1);
    check("stop_en", {31'b0, ch_enable}, 32'h0);
    check("stop_csr", ch_csr, 32'h0);
    tick();
    check("stop_end", {31'b0, ch_stop}, 32'h0);

    // Done and err together under ARS: both flags, no reload
    wr(5'(SLOT), O_TXSZ, 32'h0000_0040);
    wr(5'(SLOT), O_CSR, 32'h0000_0011);
    de_adr0 = 30'h140; de_adr0_we = 1'b1;
    tick();
    de_adr0_we = 1'b0;
    dma_done = 1'b1; dma_err = 1'b1;
    tick();
    dma_done = 1'b0; dma_err = 1'b0;
    check("de_noreload_adr0", {2'b0, ch_adr0}, 32'h140);
    check("de_noreload_csr", ch_csr, 32'h0000_6010);
    dma_busy = 1'b1;
    tick();
    check("busy_set", ch_csr, 32'h0000_7010);
    dma_busy = 1'b0;
    tick();
    check("busy_clr", ch_csr, 32'h0000_6010);

    // Disabled slot ignores everything
    wr(5'(SLOT), O_CSR, 32'hFFFF_FFFF);
    check("all_ones_csr", ch_csr, 32'h0003_803E);
    check("dis_csr", d_csr, 32'h0);
    rd(O_CSR, 32'h0003_803E);
    check("dis_dout", d_rf_dout, 32'h0);
    check("dis_fields", d_txsz | d_pointer | {2'b0, d_adr0 | d_adr1 | d_am0 | d_am1}, 32'h0);
    check("dis_flags", {29'b0, d_intt, d_enable, d_stop}, 32'h0);

    repeat (2) tick();
    check("rd_queue_empty", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_dma_ch_rf_ng.md
Name: wb_dma_ch_rf_ng

Overview:
Parametrised next-generation DMA channel register file: one slot per instance, replicated by the top-level for each channel.
- Holds CSR, transfer size, source/destination address and mask, and descriptor pointer.
- Accepts WISHBONE slave writes/reads and DMA-engine write-back updates.
- Generates a maskable, clear-on-read interrupt.
- New vs. previous generation: configurable size/address widths, optional auto-restart (ARS) reload of address/size from shadow copies, and compile-time channel removal (CH_EN=0 gives a constant-zero slot).

Parameters:
CH_ADR, 0, channel slot number; matches wb_rf_adr[7:3] and ch_sel.
CH_EN, 1, 1 = channel implemented; 0 = all outputs tied 0, all writes ignored.
TXSZ_W, 12, total transfer-size field width (1..16).
ADR_W, 30, word address width (2..30).
HAVE_ARS, 1, 1 = auto-restart logic present; 0 = CSR.ARS reads 0.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
wb_rf_adr  in  8  register address; [7:3] slot, [2:0] register
wb_rf_din  in  32  write data
wb_rf_we  in  1  write strobe, single cycle
wb_rf_re  in  1  read strobe, single cycle
rf_dout  out  32  read data, registered
ch_sel  in  5  channel currently owned by the engine
dma_busy, dma_done, dma_err, dma_chunk  in  1 each  engine status pulses, qualified by ch_sel==CH_ADR
de_csr_we, de_txsz_we, de_adr0_we, de_adr1_we  in  1 each  engine write-back strobes
de_txsz  in  TXSZ_W  engine size value
de_adr0, de_adr1  in  ADR_W  engine address values
ch_csr  out  32  CSR view
ch_txsz  out  32  {chunk[24:16], total[TXSZ_W-1:0]}
ch_adr0, ch_adr1  out  ADR_W  current addresses
ch_am0, ch_am1  out  ADR_W  address masks
pointer  out  32  descriptor pointer
ch_enable  out  1  CSR.EN & ~CSR.STOP
ch_stop  out  1  one-cycle pulse when software writes STOP=1
intt  out  1  interrupt

Behaviour:
- Register decode (hit = wb_rf_adr[7:3]==CH_ADR): offsets 0 CSR, 1 TXSZ, 2 ADR0, 3 AM0, 4 ADR1, 5 AM1, 6 POINTER; offset 7 is reserved (reads 0).
- CSR bit map:
  - [0] EN, [1] INC_SRC, [2] INC_DST, [3] MODE, [4] ARS, [5] USE_ED: read/write.
  - [6] STOP: write-1 pulse; reads 0.
  - [12] BUSY: read-only, mirrors dma_busy while selected.
  - [13] DONE, [14] ERR: read-only, sticky.
  - [17:15] INT_MSK {chunk, done, err}: read/write.
  - [20:18] INT_SRC: read-only, clear-on-read.
  - All other bits read 0.
- Reset: every register, shadow, rf_dout, intt and ch_stop are 0.
- Read: rf_dout is valid the cycle after wb_rf_re; it holds until the next read.
- Write: takes effect the cycle after wb_rf_we.
  - Any write to TXSZ/ADR0/ADR1 also loads the matching ARS shadow.
- Engine events (sel = ch_sel==CH_ADR):
  - dma_done&sel → DONE=1, EN=0.
  - dma_err&sel → ERR=1, EN=0.
  - de_*_we&sel → update the field next cycle.
  - Writing CSR with EN=1 clears DONE and ERR.
- Auto-restart (HAVE_ARS & ARS): dma_done&sel instead leaves EN=1 and DONE=0, and reloads total size, ADR0 and ADR1 from shadows the next cycle. INT_SRC.done is still set.
- Interrupt sources:
  - INT_SRC[k] sets the cycle after its event when INT_MSK[k]=1.
  - intt = |(INT_SRC & INT_MSK), registered.
  - A CSR read clears INT_SRC the cycle after wb_rf_re. An event in that same cycle wins (bit stays 1).
- Collision priority: a software write to a field overrides an engine write to the same field in the same cycle; different fields both apply.
- Simultaneous dma_done & dma_err: both DONE and ERR set; ARS reload is suppressed.
- STOP: STOP=1 write → EN=0 next cycle and ch_stop pulses for 1 cycle. STOP plus EN=1 in the same write → STOP wins.
- Size field: TXSZ writes truncate to TXSZ_W bits. The engine never underflows total; the slot does not check.
- CH_EN=0: all outputs 0 every cycle, including rf_dout for this slot.

Decomposition:
- Shared package wb_dma_ng_pkg holds:
  - register offset constants;
  - CSR bit-index constants;
  - the INT index enum {ERR, DONE, CHUNK}.
- One sub-module, wb_dma_ch_rf_ng_irq: INT_SRC set/clear-on-read logic plus intt register.

Test Plan:
- Reset mid-transfer (EN=1, INT_SRC=3'b010) with rst low → all outputs 0 immediately; rf_dout=0.
- Write CSR 0x0000_8001, engine dma_done&sel → DONE=1, EN=0, INT_SRC.chunk stays 0 (chunk masked), intt=0. Repeat with MSK=3'b010 → intt=1; CSR read returns bit18..20=3'b010; intt=0 two cycles later.
- ARS: write TXSZ=0x0010_0040, ADR0=0x100, CSR EN|ARS; engine writes txsz=0 and adr0=0x140, then dma_done → next cycle total=0x040, ch_adr0=0x100, EN=1.
- Same-cycle software ADR0=0x200 and de_adr0_we=0x300 → ch_adr0=0x200.
- CSR write EN|STOP → ch_stop=1 for exactly 1 cycle, ch_enable=0.
- CH_EN=0 instance: write CSR 0xFFFF_FFFF → ch_csr=0, intt=0, rf_dout=0.
